multicycle_alu_p: RTL and testbench

Parametrised successor to the team's 32-bit iterative ALU. Performs unsigned/signed shift-add multiply, unsigned/signed restoring divide (quotient and remainder), and bitwise AND/OR/XOR on WIDTH-bit operands, with a busy/ready handshake and an error flag. Sits behind the execute stage as the long-latency functional unit; one operation in flight at a time.

---
 rtl/multicycle_alu_p.sv | 151 +++++++++++++++
 tb/tb_multicycle_alu_p.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu_p.sv
// Iterative long-latency ALU: shift-add multiply, restoring divide and bitwise logic
// on WIDTH-bit operands, one operation in flight, busy/ready handshake.
module multicycle_alu_p #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [2:0]           mode,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic                 busy,
    output logic                 ready,
    output logic                 err,
    output logic [2*WIDTH-1:0]   out
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, MUL, DIV, LOGIC, FIX, OUT} state_t;

    typedef struct packed {
        logic [2:0]       mode;
        logic             neg_res;
        logic             neg_rem;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state;
    req_t               req;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ok;

    always_comb begin
        is_signed = (mode == 3'd1) || (mode == 3'd3);
        mag_a     = (is_signed && in_A[WIDTH-1]) ? -in_A : in_A;
        mag_b     = (is_signed && in_B[WIDTH-1]) ? -in_B : in_B;
        // opnd holds the multiplicand in MUL and the divisor in DIV
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        mul_next  = prod[0] ? {mul_sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
        div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd};
        div_ok    = ~div_diff[WIDTH+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            req   <= '0;
            cnt   <= '0;
            opnd  <= '0;
            prod  <= '0;
            rem   <= '0;
            quo   <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        req.mode    <= mode;
                        req.neg_res <= is_signed & (in_A[WIDTH-1] ^ in_B[WIDTH-1]);
                        req.neg_rem <= (mode == 3'd3) & in_A[WIDTH-1];
                        req.a       <= in_A;
                        req.b       <= in_B;
                        busy        <= 1'b1;
                        cnt         <= '0;
                        case (mode)
                            3'd0, 3'd1: begin
                                opnd  <= mag_a;
                                prod  <= {{WIDTH{1'b0}}, mag_b};
                                state <= MUL;
                            end
                            3'd2, 3'd3: begin
                                if (in_B != '0) begin
                                    opnd  <= mag_b;
                                    rem   <= '0;
                                    quo   <= mag_a;
                                    state <= DIV;
                                end else begin
                                    state <= LOGIC;
                                end
                            end
                            default: state <= LOGIC;
                        endcase
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end
                end
                DIV: begin
                    rem <= div_ok ? div_diff[WIDTH:0] : div_shift;
                    quo <= {quo[WIDTH-2:0], div_ok};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (req.mode == 3'd0 || req.mode == 3'd1) begin
                        out <= req.neg_res ? -prod : prod;
                    end else begin
                        out <= {(req.neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0]),
                                (req.neg_res ? -quo : quo)};
                    end
                    err   <= 1'b0;
                    ready <= 1'b1;
                    state <= OUT;
                end
                LOGIC: begin
                    case (req.mode)
                        3'd4: begin out <= {{WIDTH{1'b0}}, req.a & req.b}; err <= 1'b0; end
                        3'd5: begin out <= {{WIDTH{1'b0}}, req.a | req.b}; err <= 1'b0; end
                        3'd6: begin out <= {{WIDTH{1'b0}}, req.a ^ req.b}; err <= 1'b0; end
                        // only divide-by-zero reaches here with a divide mode
                        3'd2, 3'd3: begin out <= {req.a, {WIDTH{1'b1}}}; err <= 1'b1; end
                        default: begin out <= '0; err <= 1'b1; end
                    endcase
                    ready <= 1'b1;
                    state <= OUT;
                end
                OUT: begin
                    ready <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_alu_p.sv
// Directed bench for multicycle_alu_p: a WIDTH=32 instance for the main vectors and
// a WIDTH=8 instance swept against a small mulu/divu model.
module tb_multicycle_alu_p;
    logic        clk, rst;
    logic        valid32, busy32, ready32, err32;
    logic [2:0]  mode32;
    logic [31:0] a32, b32;
    logic [63:0] out32;
    logic        valid8, busy8, ready8, err8;
    logic [2:0]  mode8;
    logic [7:0]  a8, b8;
    logic [15:0] out8;

    int n_pass = 0;
    int n_total = 0;

    multicycle_alu_p #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .valid(valid32), .mode(mode32), .in_A(a32), .in_B(b32),
        .busy(busy32), .ready(ready32), .err(err32), .out(out32));

    multicycle_alu_p #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .valid(valid8), .mode(mode8), .in_A(a8), .in_B(b8),
        .busy(busy8), .ready(ready8), .err(err8), .out(out8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // lat counts cycles from the accept edge through the ready cycle inclusive
    task automatic run32(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        valid32 = 1'b1; mode32 = m; a32 = a; b32 = b;
        @(posedge clk);
        @(negedge clk);
        valid32 = 1'b0; mode32 = 3'd7; a32 = ~a; b32 = a ^ b;
        lat = 1;
        bcnt = busy32 ? 1 : 0;
        while (!ready32 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy32) bcnt++;
        end
    endtask

    task automatic run8(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        @(negedge clk);
        valid8 = 1'b1; mode8 = m; a8 = a; b8 = b;
        @(posedge clk);
        @(negedge clk);
        valid8 = 1'b0; a8 = ~a; b8 = ~b;
        lat = 1;
        while (!ready8 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt;
        logic saw_ready;
        logic [7:0] va [0:14];
        logic [7:0] vb [0:14];
        logic [15:0] exp8;

        rst = 1'b1;
        valid32 = 1'b0; mode32 = 3'd0; a32 = '0; b32 = '0;
        valid8 = 1'b0;  mode8 = 3'd0;  a8 = '0;  b8 = '0;
        repeat (3) @(negedge clk);
        chk("reset_out32", out32, 64'h0);
        chk("reset_flags32", {busy32, ready32, err32}, 3'b000);
        chk("reset_out8", out8, 16'h0);
        rst = 1'b0;

        run32(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
        chk("mulu_max_out", out32, 64'hFFFFFFFE_00000001);
        chk("mulu_max_err", err32, 1'b0);
        chk("mulu_max_lat", lat, 34);
        chk("mulu_max_busy", bcnt, 34);
        @(negedge clk);
        chk("mulu_max_after", {busy32, ready32}, 2'b00);

        run32(3'd1, 32'hFFFFFFFD, 32'd5, lat, bcnt);
        chk("mul_neg3x5", out32, 64'hFFFFFFFF_FFFFFFF1);
        chk("mul_neg3x5_lat", lat, 34);

        run32(3'd3, 32'hFFFFFFF9, 32'd2, lat, bcnt);
        chk("div_neg7_2", out32, 64'hFFFFFFFF_FFFFFFFD);
        chk("div_neg7_2_err", err32, 1'b0);

        run32(3'd3, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
        chk("div_min_m1", out32, 64'h00000000_80000000);
        chk("div_min_m1_err", err32, 1'b0);
        chk("div_min_m1_lat", lat, 34);

        run32(3'd2, 32'd100, 32'd0, lat, bcnt);
        chk("divu_by0", out32, 64'h00000064_FFFFFFFF);
        chk("divu_by0_err", err32, 1'b1);
        chk("divu_by0_lat", lat, 2);

        run32(3'd3, 32'hFFFFFFF9, 32'd0, lat, bcnt);
        chk("div_by0_signed", out32, 64'hFFFFFFF9_FFFFFFFF);
        chk("div_by0_signed_err", err32, 1'b1);

        run32(3'd7, 32'h12345678, 32'h9ABCDEF0, lat, bcnt);
        chk("illegal_out", out32, 64'h0);
        chk("illegal_err", err32, 1'b1);

        run32(3'd4, 32'hF0F0F0F0, 32'hFF00FF00, lat, bcnt);
        chk("and_out", out32, 64'h00000000_F000F000);
        run32(3'd5, 32'hF0F0F0F0, 32'hFF00FF00, lat, bcnt);
        chk("or_out", out32, 64'h00000000_FFF0FFF0);

        run32(3'd6, 32'hF0F0F0F0, 32'hFF00FF00, lat, bcnt);
        chk("xor_out", out32, 64'h00000000_0FF00FF0);
        chk("xor_err", err32, 1'b0);
        chk("xor_lat", lat, 2);
        repeat (3) @(negedge clk);
        chk("xor_hold", out32, 64'h00000000_0FF00FF0);

        // mulu with valid held high during busy, reset at iteration 10
        @(negedge clk);
        valid32 = 1'b1; mode32 = 3'd0; a32 = 32'd3; b32 = 32'd5;
        @(posedge clk);
        @(negedge clk);
        mode32 = 3'd6; a32 = 32'hDEADBEEF; b32 = 32'h01234567;
        saw_ready = 1'b0;
        repeat (10) begin
            if (ready32) saw_ready = 1'b1;
            @(negedge clk);
        end
        chk("busy_before_rst", busy32, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        valid32 = 1'b0;
        chk("no_ready_pre_rst", saw_ready, 1'b0);
        chk("rst_mid_out", out32, 64'h0);
        chk("rst_mid_flags", {busy32, ready32, err32}, 3'b000);
        repeat (2) @(negedge clk);
        chk("rst_mid_quiet", {busy32, ready32}, 2'b00);

        run32(3'd0, 32'd3, 32'd5, lat, bcnt);
        chk("post_rst_mulu", out32, 64'd15);
        chk("post_rst_lat", lat, 34);

        // WIDTH=8 sweep: corners then random
        va[0] = 8'h00; vb[0] = 8'h00;
        va[1] = 8'h00; vb[1] = 8'h01;
        va[2] = 8'h01; vb[2] = 8'h00;
        va[3] = 8'hFF; vb[3] = 8'hFF;
        va[4] = 8'h80; vb[4] = 8'hFF;
        va[5] = 8'hFF; vb[5] = 8'h01;
        va[6] = 8'h80; vb[6] = 8'h80;
        va[7] = 8'h07; vb[7] = 8'h03;
        va[8] = 8'hFF; vb[8] = 8'h00;
        for (int i = 9; i < 15; i++) begin
            va[i] = 8'($urandom_range(0, 255));
            vb[i] = 8'($urandom_range(0, 255));
        end
        for (int i = 0; i < 15; i++) begin
            run8(3'd0, va[i], vb[i], lat);
            exp8 = 16'(va[i]) * 16'(vb[i]);
            chk($sformatf("w8_mulu_%0d", i), out8, exp8);
            chk($sformatf("w8_mulu_lat_%0d", i), lat, 10);
            run8(3'd2, va[i], vb[i], lat);
            if (vb[i] == 8'h00) exp8 = {va[i], 8'hFF};
            else exp8 = {va[i] % vb[i], va[i] / vb[i]};
            chk($sformatf("w8_divu_%0d", i), out8, exp8);
            chk($sformatf("w8_divu_err_%0d", i), err8, (vb[i] == 8'h00));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
